// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module  : fifo_arb_pkg
// Brief   : Shared types and helpers for the FIFO write-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Pointer width for an n-entry round-robin; never collapses to zero bits.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Round-robin pick: rotate, priority-encode, un-rotate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [PW-1:0]     w_pos;
    logic [PW:0]       w_sum;

    // Bit 0 of w_rot corresponds to requester rr_ptr.
    assign w_dbl = {req, req} >> rr_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_pos = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_pos = PW'(i);
            end
        end
    end

    assign w_sum = {1'b0, w_pos} + {1'b0, rr_ptr};
    assign idx   = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Round-robin, burst-bounded sharing of one FIFO write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int BURST = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    input  logic                    full,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    write,
    output logic [WIDTH-1:0]        data_out,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int PW = ptr_w(NREQ);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] c_last_beat = CW'(BURST - 1);

    arb_state_t      r_state, w_state_nxt;
    logic [PW-1:0]   r_owner, w_owner_nxt;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;

    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic [PW-1:0]   w_owner_inc;
    logic            w_write;
    logic            w_release;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick)
    );

    assign w_owner_inc = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        w_gnt_nxt    = r_gnt;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && !full) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = NREQ'(1) << w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // Stalled cycles (full) leave the burst count untouched.
                if (!req[r_owner]) begin
                    w_release = 1'b1;
                end else if (w_write) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == c_last_beat) begin
                        w_release = 1'b1;
                    end
                end
                if (w_release) begin
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_owner_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_write = (r_state == GRANT) && req[r_owner] && !full && !reset;
    end

    assign write    = w_write;
    assign gnt      = r_gnt;
    assign ack      = r_gnt & {NREQ{w_write}};
    assign owner    = r_owner;
    assign data_out = data_in[r_owner*WIDTH +: WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Brief   : Self-checking bench for the FIFO write-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int BURST = 2;

    logic                  clk     = 1'b0;
    logic                  reset   = 1'b1;
    logic [NREQ-1:0]       req     = '0;
    logic [NREQ*WIDTH-1:0] data_in = '0;
    logic                  full    = 1'b0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  write;
    logic [WIDTH-1:0]      data_out;
    logic [1:0]            owner;

    int checks = 0;
    int errors = 0;

    // Reference state: who holds the port, beats taken, next search start.
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;

    fifo_wr_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .BURST (BURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .full     (full),
        .gnt      (gnt),
        .ack      (ack),
        .write    (write),
        .data_out (data_out),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    task automatic clk_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] v);
        data_in[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        full  = 1'b0;
        repeat (2) clk_cycle();
        reset   = 1'b0;
        m_busy  = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_release();
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
    endtask

    // Advance the reference by one clock using the inputs present now.
    task automatic model_step();
        bit hit;
        if (reset) begin
            m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else if (!m_busy) begin
            hit = 1'b0;
            if (req != 0 && !full) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!hit && req[(m_ptr + k) % NREQ]) begin
                        hit     = 1'b1;
                        m_busy  = 1'b1;
                        m_owner = (m_ptr + k) % NREQ;
                        m_cnt   = 0;
                    end
                end
            end
        end else if (!req[m_owner]) begin
            model_release();
        end else if (!full) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == BURST) model_release();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        full  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            clk_cycle();
            #1;
            checks++;
            if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
            checks++;
            if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", write); end
        end
        reset = 1'b0;
        clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] words [3];
        bit expw [5];
        int widx;
        words = '{4'd3, 4'd5, 4'd7};
        expw  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        req  = 4'b0100;
        widx = 0;
        set_word(2, words[0]);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (write !== expw[c]) begin errors++; $display("FAIL single_write c%0d: got %b expected %b", c, write, expw[c]); end
            if (write && widx < 3) begin
                checks++;
                if (data_out !== words[widx]) begin errors++; $display("FAIL single_data c%0d: got %0d expected %0d", c, data_out, words[widx]); end
                widx++;
            end
            if (c == 4) begin
                checks++;
                if (gnt !== 4'b0100) begin errors++; $display("FAIL single_regrant: got %b expected 0100", gnt); end
            end
            clk_cycle();
            if (widx < 3) set_word(2, words[widx]);
        end
        checks++;
        if (widx !== 3) begin errors++; $display("FAIL single_count: got %0d expected 3", widx); end
        req = '0;
    endtask

    task automatic test_contention();
        int own;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_word(i, 4'(i * 3 + 1));
        req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            #1;
            own = ((c - 1) / 3) % NREQ;
            if (c % 3 == 0) begin
                checks++;
                if (write !== 1'b0 || gnt !== 4'b0000) begin
                    errors++; $display("FAIL contention_bubble c%0d: got write=%b gnt=%b expected write=0 gnt=0000", c, write, gnt);
                end
            end else begin
                checks++;
                if (write !== 1'b1 || gnt !== 4'(1 << own)) begin
                    errors++; $display("FAIL contention_grant c%0d: got write=%b gnt=%b expected write=1 gnt=%b", c, write, gnt, 4'(1 << own));
                end
                checks++;
                if (data_out !== 4'(own * 3 + 1)) begin
                    errors++; $display("FAIL contention_data c%0d: got %0d expected %0d", c, data_out, own * 3 + 1);
                end
            end
            clk_cycle();
        end
        req = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b0010;
        clk_cycle();
        #1;
        checks++;
        if (write !== 1'b1 || gnt !== 4'b0010) begin errors++; $display("FAIL stall_first: got write=%b gnt=%b expected write=1 gnt=0010", write, gnt); end
        clk_cycle();
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (write !== 1'b0 || gnt !== 4'b0010 || ack !== 4'b0000) begin
                errors++; $display("FAIL stall_hold c%0d: got write=%b gnt=%b ack=%b expected write=0 gnt=0010 ack=0000", c, write, gnt, ack);
            end
            clk_cycle();
        end
        full = 1'b0;
        #1;
        checks++;
        if (write !== 1'b1 || ack !== 4'b0010) begin errors++; $display("FAIL stall_resume: got write=%b ack=%b expected write=1 ack=0010", write, ack); end
        clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL stall_release: got %b expected 0000", gnt); end
        req = '0;
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 4'b0100;
        clk_cycle();
        #1;
        checks++;
        if (write !== 1'b1 || gnt !== 4'b0100) begin errors++; $display("FAIL drop_first: got write=%b gnt=%b expected write=1 gnt=0100", write, gnt); end
        clk_cycle();
        req = 4'b1001;
        #1;
        checks++;
        if (write !== 1'b0 || gnt !== 4'b0100) begin errors++; $display("FAIL drop_same_cycle: got write=%b gnt=%b expected write=0 gnt=0100", write, gnt); end
        clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_release: got %b expected 0000", gnt); end
        clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b1000 || write !== 1'b1) begin errors++; $display("FAIL drop_next_owner: got gnt=%b write=%b expected gnt=1000 write=1", gnt, write); end
        repeat (2) clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_bubble: got %b expected 0000", gnt); end
        clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_wrap: got %b expected 0001", gnt); end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        repeat (3) clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst_pre_release: got %b expected 0000", gnt); end
        req = 4'b1000;
        clk_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b1000 || write !== 1'b0) begin errors++; $display("FAIL midrst_gate: got gnt=%b write=%b expected gnt=1000 write=0", gnt, write); end
        clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst_clear: got %b expected 0000", gnt); end
        reset = 1'b0;
        req   = 4'b1111;
        clk_cycle();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_ptr: got %b expected 0001", gnt); end
        req = '0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0]  exp_gnt;
        logic             exp_write;
        logic [WIDTH-1:0] exp_data;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req     = 4'($urandom);
            full    = ($urandom_range(0, 3) == 0);
            data_in = 16'($urandom);
            reset   = ($urandom_range(0, 49) == 0);
            #1;
            exp_gnt   = m_busy ? 4'(1 << m_owner) : 4'b0000;
            exp_write = m_busy && req[m_owner] && !full && !reset;
            exp_data  = data_in[m_owner*WIDTH +: WIDTH];
            checks++;
            if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, gnt, exp_gnt); end
            checks++;
            if (write !== exp_write) begin errors++; $display("FAIL rand_write c%0d: got %b expected %b", c, write, exp_write); end
            checks++;
            if (ack !== (exp_write ? exp_gnt : 4'b0000)) begin errors++; $display("FAIL rand_ack c%0d: got %b expected %b", c, ack, exp_write ? exp_gnt : 4'b0000); end
            checks++;
            if (data_out !== exp_data) begin errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, data_out, exp_data); end
            if (m_busy) begin
                checks++;
                if (owner !== 2'(m_owner)) begin errors++; $display("FAIL rand_owner c%0d: got %0d expected %0d", c, owner, m_owner); end
            end
            model_step();
            clk_cycle();
        end
        reset = 1'b0;
        req   = '0;
        full  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_early_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a FIFO among NREQ requesters. Grants one requester at a time for a bounded burst and forwards that requester's data and write strobe to the FIFO. Stalls on the FIFO's full flag without losing data. Sits between the producer blocks and the FIFO write side, in the FIFO's write-clock domain.

## Interface
- WIDTH, 4: data width per requester, equal to FIFO data width
- NREQ, 4: number of requesters, 2..8
- BURST, 2: maximum accepted writes per grant, ≥1
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  req[i] high = requester i has a valid word on its data slice
- data_in  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- full  in  1  FIFO full flag
- gnt  out  NREQ  registered one-hot grant, all-zero when idle
- ack  out  NREQ  gnt & {NREQ{write}}; requester i presents its next word the cycle after ack[i]
- write  out  1  FIFO write strobe
- data_out  out  WIDTH  data slice of the current owner
- owner  out  $clog2(NREQ)  index of the current owner, valid while gnt≠0

## Operation
- States: IDLE, GRANT. Registers: state, owner, rr_ptr, cnt ($clog2(BURST+1) bits), gnt.
- Reset: state=IDLE, gnt=0, owner=0, rr_ptr=0, cnt=0. Hence write=0, ack=0, data_out=data_in[WIDTH-1:0].
- IDLE: if |req && !full, pick first i with req[i] searching rr_ptr, rr_ptr+1, … mod NREQ; owner<=i, gnt<=1<<i, cnt<=0, go GRANT. With full=1 or req=0, stay IDLE.
- GRANT: write = req[owner] && !full (combinational). data_out = owner's slice.
- On write: cnt<=cnt+1. If cnt==BURST-1, release.
- If req[owner]=0, release regardless of cnt.
- full=1 with req[owner]=1: hold grant, write=0, cnt unchanged; stall cycles do not consume burst.
- Release: gnt<=0, rr_ptr<=(owner+1) mod NREQ, state<=IDLE.
- Requests from non-owners never generate write. Changes to req of non-owners during GRANT are ignored until the next IDLE.
- Reset asserted mid-burst: next edge forces the reset values. No partial word is written in the reset cycle, because write is gated to 0 when reset=1.

## Timing
- Grant latency: req seen in IDLE at cycle n → gnt at n+1, first write at n+1 if req and !full.
- Full burst: writes at n+1..n+BURST, gnt=0 at n+BURST+1, earliest next gnt at n+BURST+2 (one arbitration bubble per handover).
- full is sampled combinationally in the same cycle. write never asserts in a cycle where full=1.
- Owner drops req at cycle m → write=0 at m, gnt=0 at m+1.
- Throughput: at most BURST writes per BURST+1 cycles under continuous contention.

## Structure
- Shared package fifo_arb_pkg: state enum (IDLE, GRANT) and localparam helper for pointer width.
- One combinational sub-module rr_pick: inputs req, rr_ptr; outputs found and idx. It is a rotate, priority-encode and un-rotate chain.
- The top module holds the FSM, counters, grant register and output mux.

## Test plan
Defaults for all scenarios: NREQ=4, BURST=2, WIDTH=4.
- Reset: reset=1 for 2 cycles, req=4'b1111 → gnt=0, write=0 throughout. After release, first gnt=4'b0001.
- Single requester: req=4'b0100, data 3,5,7 on successive acks, full=0 → writes 3,5 (cycles n+1,n+2), bubble, writes 7. rr_ptr goes 3 then 3.
- Contention: req=4'b1111 constant → grant order 0,1,2,3,0. Each owner gets exactly 2 writes, and write is low for one cycle between owners.
- Full stall: owner 1 after first write, full=1 for 3 cycles → write=0, gnt=4'b0010 held. After full=0, one more write, then release.
- Early drop: owner 2 drops req after 1 write → gnt=0 next cycle, rr_ptr=3. Pending req[0] is granted after req[3] if both are high.
- Reset mid-burst: reset=1 while gnt=4'b1000 with write pending → write=0 that cycle, next cycle gnt=0, rr_ptr=0.
